// File: rtl/bp_update_sched_if.sv
// bp_update_sched_if
//   Bundles the three buses around the predictor update scheduler:
//   fetch lookup (req/pc/opcode -> stall, pred_valid/pred_taken),
//   EX resolve handshake (valid/pc/taken/pred -> ready),
//   and the gshare predictor port (start/address/opcode/update -> prediction).
//   slave  : the scheduler side
//   master : the pipeline + predictor side (drives the scheduler inputs)
// Parameters
//   ADDR_W  branch/update address width, must match the scheduler
interface bp_update_sched_if #(
  parameter int ADDR_W = 8
);
  logic              lookup_req;
  logic [ADDR_W-1:0] lookup_pc;
  logic [6:0]        lookup_opcode;
  logic              lookup_stall;
  logic              pred_valid;
  logic              pred_taken;

  logic              resolve_valid;
  logic [ADDR_W-1:0] resolve_pc;
  logic              resolve_taken;
  logic              resolve_pred;
  logic              resolve_ready;

  logic              bp_start;
  logic [ADDR_W-1:0] bp_branch_address;
  logic [6:0]        bp_opcode;
  logic              bp_prediction;
  logic              bp_update;
  logic [ADDR_W-1:0] bp_update_address;
  logic              bp_branch_taken;

  modport slave (
    input  lookup_req, lookup_pc, lookup_opcode,
    output lookup_stall, pred_valid, pred_taken,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_pred,
    output resolve_ready,
    output bp_start, bp_branch_address, bp_opcode,
    input  bp_prediction,
    output bp_update, bp_update_address, bp_branch_taken
  );

  modport master (
    output lookup_req, lookup_pc, lookup_opcode,
    input  lookup_stall, pred_valid, pred_taken,
    output resolve_valid, resolve_pc, resolve_taken, resolve_pred,
    input  resolve_ready,
    input  bp_start, bp_branch_address, bp_opcode,
    output bp_prediction,
    input  bp_update, bp_update_address, bp_branch_taken
  );
endinterface

// File: rtl/bp_update_sched.sv
// bp_update_sched
//   Arbitrates the gshare predictor's shared GHR/BHT between front-end
//   lookups and back-end outcome updates. Resolved branches are queued in a
//   small FIFO and drained as isolated 1-cycle update pulses (high one cycle,
//   low at least two). Lookups have priority unless the oldest queued update
//   has already been deferred MAX_DEFER cycles, in which case it is forced
//   out and the lookup stalls for that cycle.
// Ports
//   clk   system clock, posedge
//   rst   synchronous active-high reset
//   bus   bp_update_sched_if.slave (lookup, resolve and predictor buses)
//   stat_updates / stat_mispred  (only with BP_STATS_EN) issued-update and
//         mispredicted-update counters, wrap at 2^32
// Configuration
//   BP_STATS_EN  define to add the statistics counters and their ports
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | may issue the FIFO head as an update pulse
// PULSE | bp_update is high this cycle; lookups blocked
// GAP   | bp_update low phase before the next pulse; lookups blocked
module bp_update_sched #(
  parameter int ADDR_W    = 8,
  parameter int QDEPTH    = 4,
  parameter int MAX_DEFER = 7
) (
  input  logic                clk,
  input  logic                rst,
  bp_update_sched_if.slave    bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispred
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int DEF_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam int ENT_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state;

  // FIFO entry layout: {pc, taken, pred}
  logic [ENT_W-1:0]   q_mem [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [DEF_W-1:0]   defer_cnt;

  logic [ADDR_W-1:0]  upd_addr_q;
  logic               upd_taken_q;
  logic               upd_q;
  logic               pred_valid_q;
  logic               pred_taken_q;

  logic               q_nonempty;
  logic               defer_max;
  logic               forced;
  logic               issue;
  logic               block;
  logic               start_c;
  logic               ready_c;
  logic               push;
  logic [ENT_W-1:0]   head;
  logic [ADDR_W-1:0]  head_pc;
  logic               head_taken;
  logic               head_pred;

  assign q_nonempty = (count != '0);
  assign defer_max  = (defer_cnt == DEF_W'(MAX_DEFER));
  assign ready_c    = (count != CNT_W'(QDEPTH));
  assign push       = bus.resolve_valid & ready_c;

  // An update is issued from IDLE when the fetch side is quiet, or when the
  // head has been starved long enough that it must go regardless.
  assign forced     = (state == S_IDLE) && q_nonempty && defer_max;
  assign issue      = (state == S_IDLE) && q_nonempty && (!bus.lookup_req || defer_max);

  // The predictor's shared state is busy from the issuing cycle through the
  // low phase, so lookups are held off for the whole pulse/gap window.
  assign block      = (state != S_IDLE) || forced;
  assign start_c    = bus.lookup_req & ~block;

  assign head       = q_mem[rd_ptr];
  assign head_pc    = head[ENT_W-1:2];
  assign head_taken = head[1];
  assign head_pred  = head[0];

  assign bus.lookup_stall      = bus.lookup_req & block;
  assign bus.bp_start          = start_c;
  assign bus.bp_branch_address = bus.lookup_pc;
  assign bus.bp_opcode         = bus.lookup_opcode;
  assign bus.resolve_ready     = ready_c;
  assign bus.pred_valid        = pred_valid_q;
  assign bus.pred_taken        = pred_taken_q;
  assign bus.bp_update         = upd_q;
  assign bus.bp_update_address = upd_addr_q;
  assign bus.bp_branch_taken   = upd_taken_q;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= {bus.resolve_pc, bus.resolve_taken, bus.resolve_pred};
    end
  end

  // FIFO pointers/occupancy and the head's deferral counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      defer_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Deferral is measured only while the head sits in IDLE behind a
      // lookup; PULSE/GAP time does not count against the next entry.
      if (issue || !q_nonempty) begin
        defer_cnt <= '0;
      end else if ((state == S_IDLE) && bus.lookup_req && !defer_max) begin
        defer_cnt <= defer_cnt + DEF_W'(1);
      end
    end
  end

  // Update-pulse FSM with its registered outputs, plus the lookup result
  // pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      upd_q        <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= start_c;
      pred_taken_q <= start_c ? bus.bp_prediction : 1'b0;

      case (state)
        S_IDLE: begin
          if (issue) begin
            upd_addr_q  <= head_pc;
            upd_taken_q <= head_taken;
            upd_q       <= 1'b1;
            state       <= S_PULSE;
          end
        end
        S_PULSE: begin
          upd_q <= 1'b0;
          state <= S_GAP;
        end
        S_GAP: begin
          upd_q <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          upd_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (issue) begin
      stat_updates <= stat_updates + 32'd1;
      if (head_taken != head_pred) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`else
  // Prediction bit is only consumed by the statistics counters.
  logic unused_pred;
  assign unused_pred = head_pred;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
module tb_bp_update_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_update_sched_if #(.ADDR_W(8)) bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  bp_update_sched #(
    .ADDR_W   (8),
    .QDEPTH   (4),
    .MAX_DEFER(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BP_STATS_EN
    ,
    .stat_updates (stat_updates),
    .stat_mispred (stat_mispred)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] pc;
    logic       taken;
  } upd_t;
  upd_t sb[$];

  typedef struct {
    logic       req;
    logic [7:0] pc;
    logic [6:0] op;
    logic       pred;
    logic       exp_start;
    logic       exp_pv;
    logic       exp_pt;
  } lk_vec_t;
  lk_vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lookup_req    = 1'b0;
    bus.lookup_pc     = 8'h00;
    bus.lookup_opcode = 7'h00;
    bus.resolve_valid = 1'b0;
    bus.resolve_pc    = 8'h00;
    bus.resolve_taken = 1'b0;
    bus.resolve_pred  = 1'b0;
    bus.bp_prediction = 1'b0;
  endtask

  task automatic resolve(input logic [7:0] pc, input logic taken, input logic pred);
    bus.resolve_valid = 1'b1;
    bus.resolve_pc    = pc;
    bus.resolve_taken = taken;
    bus.resolve_pred  = pred;
  endtask

  // Scoreboard: an accepted resolve pushes its expected update; each
  // bp_update pulse pops and compares, and must follow a low cycle.
  task automatic monitor();
    upd_t e;
    logic prev_upd;
    prev_upd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_upd = 1'b0;
      end else begin
        if (bus.bp_update) begin
          chk("pulse_prev_low", 32'(prev_upd), 32'd0);
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected_update: got pulse addr 0x%0h, want no pulse", bus.bp_update_address);
          end else begin
            e = sb.pop_front();
            chk("upd_addr", 32'(bus.bp_update_address), 32'(e.pc));
            chk("upd_taken", 32'(bus.bp_branch_taken), 32'(e.taken));
          end
        end
        prev_upd = bus.bp_update;
        if (bus.resolve_valid && bus.resolve_ready) begin
          e.pc    = bus.resolve_pc;
          e.taken = bus.resolve_taken;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    chk(name, 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_bp_update"},  32'(bus.bp_update), 32'd0);
    chk({tag, "_pred_valid"}, 32'(bus.pred_valid), 32'd0);
    chk({tag, "_pred_taken"}, 32'(bus.pred_taken), 32'd0);
    chk({tag, "_ready"},      32'(bus.resolve_ready), 32'd1);
    chk({tag, "_upd_addr"},   32'(bus.bp_update_address), 32'd0);
    chk({tag, "_upd_taken"},  32'(bus.bp_branch_taken), 32'd0);
`ifdef BP_STATS_EN
    chk({tag, "_stat_upd"},   stat_updates, 32'd0);
    chk({tag, "_stat_mis"},   stat_mispred, 32'd0);
`endif
  endtask

  initial begin
    int np;
    int stalls_early;
    logic [6:0] pat;

    vecs[0] = '{1'b1, 8'h10, 7'h63, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'hA5, 7'h63, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h22, 7'h13, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 7'h6F, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'h00, 7'h67, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    idle_inputs();
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    bus.lookup_req = 1'b1;
    bus.lookup_pc  = 8'h33;
    @(negedge clk);
    check_reset_state("rst");
    chk("rst_lookup_stall", 32'(bus.lookup_stall), 32'd0);
    chk("rst_bp_start", 32'(bus.bp_start), 32'd1);
    tick();
    idle_inputs();
    tick();

    // Lookup vectors, FIFO empty
    for (int v = 0; v < 5; v++) begin
      bus.lookup_req    = vecs[v].req;
      bus.lookup_pc     = vecs[v].pc;
      bus.lookup_opcode = vecs[v].op;
      bus.bp_prediction = vecs[v].pred;
      @(negedge clk);
      chk("lk_bp_start", 32'(bus.bp_start), 32'(vecs[v].exp_start));
      chk("lk_stall", 32'(bus.lookup_stall), 32'd0);
      chk("lk_addr", 32'(bus.bp_branch_address), 32'(vecs[v].pc));
      chk("lk_opcode", 32'(bus.bp_opcode), 32'(vecs[v].op));
      tick();
      idle_inputs();
      @(negedge clk);
      chk("lk_pred_valid", 32'(bus.pred_valid), 32'(vecs[v].exp_pv));
      chk("lk_pred_taken", 32'(bus.pred_taken), 32'(vecs[v].exp_pt));
      tick();
    end

    // Single update: accepted at N, pulse only at N+2
    resolve(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    chk("single_ready", 32'(bus.resolve_ready), 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("single_n1_low", 32'(bus.bp_update), 32'd0);
    tick();
    @(negedge clk);
    chk("single_n2_high", 32'(bus.bp_update), 32'd1);
    chk("single_addr", 32'(bus.bp_update_address), 32'h3C);
    chk("single_taken", 32'(bus.bp_branch_taken), 32'd1);
    tick();
    @(negedge clk);
    chk("single_n3_low", 32'(bus.bp_update), 32'd0);
    drain("single_drain");

    // Pulse shape: three queued, no lookups -> 1,0,0,1,0,0,1
    pat = '0;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      if (c < 3) resolve(8'h40 + 8'(c), c[0], 1'b1);
      @(negedge clk);
      if (c >= 2) pat = {pat[5:0], bus.bp_update};
      tick();
    end
    chk("pulse_pattern", 32'(pat), 32'b1001001);
    idle_inputs();
    drain("pulse_drain");

    // Fill under continuous lookups; head forced after 7 deferrals
    np = 0;
    stalls_early = 0;
    for (int c = 0; c < 12; c++) begin
      bus.lookup_req    = 1'b1;
      bus.lookup_pc     = 8'(c);
      bus.lookup_opcode = 7'h63;
      bus.bp_prediction = 1'($urandom_range(0, 1));
      if (np < 5) resolve(8'h80 + 8'(np), np[0], 1'b0);
      else bus.resolve_valid = 1'b0;
      @(negedge clk);
      if (c == 3) chk("fill_ready_c3", 32'(bus.resolve_ready), 32'd1);
      if (c == 4) chk("fill_ready_c4", 32'(bus.resolve_ready), 32'd0);
      if (c >= 1 && c <= 7 && bus.lookup_stall) stalls_early++;
      if (c == 8) begin
        chk("fill_forced_stall", 32'(bus.lookup_stall), 32'd1);
        chk("fill_forced_nostart", 32'(bus.bp_start), 32'd0);
      end
      if (c == 9) chk("fill_forced_pulse", 32'(bus.bp_update), 32'd1);
      if (bus.resolve_valid && bus.resolve_ready) np++;
      tick();
    end
    chk("fill_early_stalls", 32'(stalls_early), 32'd0);
    chk("fill_all_accepted", 32'(np), 32'd5);
    idle_inputs();
    drain("fill_drain");

    // Reset during PULSE
    resolve(8'h5A, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pulse_high", 32'(bus.bp_update), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rstmid");
    tick();

    // Four updates, two mispredicted
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      resolve(8'hC0 + 8'(c), ~c[1], c[1] ^ ~c[0]);
      tick();
    end
    idle_inputs();
    drain("stats_drain");
`ifdef BP_STATS_EN
    @(negedge clk);
    chk("stat_updates", stat_updates, 32'd4);
    chk("stat_mispred", stat_mispred, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
